// File: rtl/mel_filterbank_pkg.sv
// Shared constants, weight-ROM word layout and arithmetic helpers for the mel filterbank.
package mel_filterbank_pkg;

   localparam int unsigned NF_IN    = 512;  // bins per input frame
   localparam int unsigned NUM_BINS = 257;  // bins that carry spectrum (0..NF_IN/2)
   localparam int unsigned NUM_MEL  = 26;   // number of triangular filters
   localparam int unsigned IN_W     = 32;
   localparam int unsigned ACC_W    = 40;
   localparam int unsigned OUT_W    = 32;
   localparam int unsigned W_FRAC   = 15;
   localparam int unsigned BIN_W    = $clog2(NF_IN);
   localparam int unsigned SEG_W    = 6;
   localparam int unsigned WGT_W    = 16;
   localparam int unsigned PROD_W   = IN_W + WGT_W;     // full product width
   localparam int unsigned TERM_W   = PROD_W - W_FRAC;  // product after the Q15 shift
   localparam int unsigned IDX_W    = 5;

   localparam logic [WGT_W-1:0] W_ONE    = 16'h8000;  // weight of 1.0
   localparam logic [SEG_W-1:0] SEG_NONE = 6'h3F;     // bin feeds no filter

   // Built-in weight image: segments start at this bin and widen slowly with index
   localparam int unsigned DEF_FIRST_BIN = 2;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   typedef struct packed {
      logic [SEG_W-1:0] seg;
      logic [WGT_W-1:0] w;
   } rom_word_t;

   typedef rom_word_t [NUM_BINS-1:0] rom_image_t;

   // Weight word for bin k: segment s spans 4 + 2*(s/6) bins, w ramps 0 -> just below 1.0
   function automatic rom_word_t default_rom_word(input int unsigned k);
      rom_word_t   r;
      int unsigned lo;
      int unsigned wd;
      r.seg = SEG_NONE;
      r.w   = '0;
      lo    = DEF_FIRST_BIN;
      for (int unsigned s = 0; s <= NUM_MEL; s++) begin
         wd = 4 + 2 * (s / 6);
         if (k >= lo && k < lo + wd) begin
            r.seg = SEG_W'(s);
            r.w   = WGT_W'(((k - lo) << W_FRAC) / wd);
         end
         lo = lo + wd;
      end
      return r;
   endfunction

   function automatic rom_image_t build_rom_image();
      rom_image_t img;
      for (int unsigned k = 0; k < NUM_BINS; k++) begin
         img[k] = default_rom_word(k);
      end
      return img;
   endfunction

   // Saturating accumulator add; both operands are non-negative
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

   // Clamp an accumulator to the output width
   function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] acc);
      return (|acc[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/mel_weight_rom.sv
// Per-bin triangular-filter weight ROM with a registered read port.
module mel_weight_rom
   import mel_filterbank_pkg::*;
(
   input  logic             clk,
   input  logic             i_en,
   input  logic [BIN_W-1:0] i_addr,
   output rom_word_t        o_word
);

   localparam rom_image_t ROM_IMAGE = build_rom_image();
   localparam rom_word_t  NONE_WORD = {SEG_NONE, {WGT_W{1'b0}}};

   logic      w_in_range;
   rom_word_t r_word;

   assign w_in_range = (32'(i_addr) < NUM_BINS);
   assign o_word     = r_word;

   // Registered read; addresses past the table read back as "no filter"
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (w_in_range) begin
            r_word <= ROM_IMAGE[i_addr];
         end else begin
            r_word <= NONE_WORD;
         end
      end
   end

endmodule

// File: rtl/mel_filterbank.sv
// Mel filterbank: folds a periodogram frame into NUM_MEL triangular filter energies.
// Three valid-qualified stages (register / weight / accumulate) plus a one-cycle flush.
module mel_filterbank
   import mel_filterbank_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  power_in,
   input  logic             power_valid,
   output logic [OUT_W-1:0] mel_out,
   output logic [IDX_W-1:0] mel_index,
   output logic             mel_valid,
   output logic             frame_done
);

   // Bin counter and stage 0
   logic [BIN_W-1:0]  r_bin;
   logic              r_s0_valid;
   logic              r_s0_first;
   logic              r_s0_use;
   logic              r_s0_last;
   logic [IN_W-1:0]   r_s0_power;
   rom_word_t         w_rom_word;

   // Stage 1
   logic [PROD_W-1:0] w_rise_prod;
   logic [PROD_W-1:0] w_fall_prod;
   logic              r_s1_valid;
   logic              r_s1_first;
   logic              r_s1_use;
   logic              r_s1_last;
   logic [SEG_W-1:0]  r_s1_seg;
   logic [TERM_W-1:0] r_s1_rise;
   logic [TERM_W-1:0] r_s1_fall;

   // Stage 2 accumulators and control
   logic [ACC_W-1:0]  r_acc_rise;
   logic [ACC_W-1:0]  r_acc_fall;
   logic [SEG_W-1:0]  r_cur_seg;
   logic [0:0]        r_state;
   logic [ACC_W-1:0]  w_base_rise;
   logic [ACC_W-1:0]  w_base_fall;
   logic [SEG_W-1:0]  w_base_seg;
   logic [ACC_W-1:0]  w_acc_rise_d;
   logic [ACC_W-1:0]  w_acc_fall_d;
   logic [SEG_W-1:0]  w_cur_seg_d;
   logic [0:0]        w_state_d;
   logic              w_flush;
   logic              w_s1_active;
   logic              w_emit;
   logic              w_emit_last;
   logic [IDX_W-1:0]  w_emit_idx;
   logic [OUT_W-1:0]  w_emit_val;

   // Output registers
   logic [OUT_W-1:0]  r_mel_out;
   logic [IDX_W-1:0]  r_mel_index;
   logic              r_mel_valid;
   logic              r_frame_done;

   mel_weight_rom u_rom (
      .clk    (clk),
      .i_en   (power_valid),
      .i_addr (r_bin),
      .o_word (w_rom_word)
   );

   // Count valid beats and capture the bin value alongside the ROM read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin      <= '0;
         r_s0_valid <= 1'b0;
         r_s0_first <= 1'b0;
         r_s0_use   <= 1'b0;
         r_s0_last  <= 1'b0;
         r_s0_power <= '0;
      end else begin
         r_s0_valid <= power_valid;
         if (power_valid) begin
            r_bin      <= (r_bin == BIN_W'(NF_IN - 1)) ? '0 : r_bin + 1'b1;
            r_s0_first <= (r_bin == '0);
            r_s0_use   <= (32'(r_bin) < NUM_BINS);
            r_s0_last  <= (32'(r_bin) == NUM_BINS - 1);
            r_s0_power <= power_in;
         end
      end
   end

   assign w_rise_prod = PROD_W'(r_s0_power) * PROD_W'(w_rom_word.w);
   assign w_fall_prod = PROD_W'(r_s0_power) * PROD_W'(W_ONE - w_rom_word.w);

   // Weight the bin into its rising and falling contributions
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_use   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_seg   <= SEG_NONE;
         r_s1_rise  <= '0;
         r_s1_fall  <= '0;
      end else begin
         r_s1_valid <= r_s0_valid;
         if (r_s0_valid) begin
            r_s1_first <= r_s0_first;
            r_s1_use   <= r_s0_use;
            r_s1_last  <= r_s0_last;
            r_s1_seg   <= w_rom_word.seg;
            r_s1_rise  <= w_rise_prod[PROD_W-1:W_FRAC];
            r_s1_fall  <= w_fall_prod[PROD_W-1:W_FRAC];
         end
      end
   end

   // Accumulate into the open filters and decide on an emission this cycle
   always_comb begin
      w_flush     = (r_state == ST_FLUSH);
      w_s1_active = r_s1_valid && r_s1_use && (r_s1_seg != SEG_NONE);
      // Bin 0 and the flush both restart from empty accumulators
      w_base_rise = (w_flush || (r_s1_valid && r_s1_first)) ? '0 : r_acc_rise;
      w_base_fall = (w_flush || (r_s1_valid && r_s1_first)) ? '0 : r_acc_fall;
      w_base_seg  = (r_s1_valid && r_s1_first) ? '0 : r_cur_seg;

      w_acc_rise_d = w_base_rise;
      w_acc_fall_d = w_base_fall;
      w_cur_seg_d  = w_base_seg;

      // The flush closes the last filter from the pre-clear accumulator
      w_emit      = w_flush;
      w_emit_last = w_flush;
      w_emit_idx  = IDX_W'(NUM_MEL - 1);
      w_emit_val  = sat_out(r_acc_fall);

      if (w_s1_active) begin
         if (r_s1_seg == w_base_seg) begin
            if (w_base_seg != '0) begin
               w_acc_fall_d = sat_add(w_base_fall, ACC_W'(r_s1_fall));
            end
            w_acc_rise_d = sat_add(w_base_rise, ACC_W'(r_s1_rise));
         end else if (r_s1_seg == w_base_seg + 6'd1) begin
            // Crossing a centre point: the falling filter is complete
            if (w_base_seg != '0) begin
               w_emit      = 1'b1;
               w_emit_last = 1'b0;
               w_emit_idx  = IDX_W'(w_base_seg - 6'd1);
               w_emit_val  = sat_out(w_base_fall);
            end
            w_acc_fall_d = sat_add(w_base_rise, ACC_W'(r_s1_fall));
            w_acc_rise_d = ACC_W'(r_s1_rise);
            w_cur_seg_d  = w_base_seg + 6'd1;
         end
      end
   end

   // Frame FSM: one flush cycle after the last used bin leaves stage 2
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (r_s1_valid && r_s1_last) begin
               w_state_d = ST_FLUSH;
            end
         end
         default: w_state_d = ST_ACCUM;
      endcase
   end

   // Accumulator, segment tracker and FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_rise <= '0;
         r_acc_fall <= '0;
         r_cur_seg  <= '0;
         r_state    <= ST_ACCUM;
      end else begin
         r_acc_rise <= w_acc_rise_d;
         r_acc_fall <= w_acc_fall_d;
         r_cur_seg  <= w_cur_seg_d;
         r_state    <= w_state_d;
      end
   end

   // Register the emitted energy; the value holds between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mel_out    <= '0;
         r_mel_index  <= '0;
         r_mel_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_mel_valid  <= w_emit;
         r_frame_done <= w_emit_last;
         if (w_emit) begin
            r_mel_out   <= w_emit_val;
            r_mel_index <= w_emit_idx;
         end
      end
   end

   assign mel_out    = r_mel_out;
   assign mel_index  = r_mel_index;
   assign mel_valid  = r_mel_valid;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mel_filterbank.sv
// Scoreboard bench for mel_filterbank: a frame-level filter model queues expected
// strobes (index, energy, frame_done, cycle); a monitor pops and compares each strobe.
module tb_mel_filterbank;
   import mel_filterbank_pkg::*;

   localparam int NB   = int'(NUM_BINS);
   localparam int NM   = int'(NUM_MEL);
   localparam int NF   = int'(NF_IN);

   typedef struct {
      int          idx;
      logic [31:0] val;
      logic        last;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] power_in;
   logic        power_valid;
   logic [31:0] mel_out;
   logic [4:0]  mel_index;
   logic        mel_valid;
   logic        frame_done;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   exp_t        q[$];
   rom_word_t   tbl [NB];
   logic [31:0] frm [NF];

   mel_filterbank u_dut (
      .clk         (clk),
      .rst         (rst),
      .power_in    (power_in),
      .power_valid (power_valid),
      .mel_out     (mel_out),
      .mel_index   (mel_index),
      .mel_valid   (mel_valid),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (frame_done && !mel_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_alone: got frame_done=1 with mel_valid=0 (cycle %0d)", cyc);
         end
         if (mel_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_strobe: got index %0d value 0x%0h, expected none",
                        mel_index, mel_out);
            end else begin
               x = q.pop_front();
               check("mel_index", 64'(mel_index), 64'(x.idx));
               check("mel_out", 64'(mel_out), 64'(x.val));
               check("frame_done", 64'(frame_done), 64'(x.last));
               check("latency_cycle", 64'(cyc), 64'(x.due));
            end
         end
      end
   end

   // Drive n_beats bins of frm[] with random idle gaps, queueing the model's strobes
   task automatic run_frame(input int n_beats, input int gap_max);
      longint unsigned e [NM];
      int              trig [NM];
      longint unsigned p;
      longint unsigned w;
      int              s;
      int              g;
      exp_t            x;
      for (int m = 0; m < NM; m++) begin
         e[m]    = 0;
         trig[m] = -1;
      end
      // Filter m rises over segment m and falls over segment m+1
      for (int k = 0; k < NB; k++) begin
         if (tbl[k].seg != SEG_NONE) begin
            s = int'(tbl[k].seg);
            p = 64'(frm[k]);
            w = 64'(tbl[k].w);
            if (s < NM) e[s] += (p * w) >> 15;
            if (s >= 1) e[s-1] += (p * (64'd32768 - w)) >> 15;
            // Filter m is complete once the stream reaches segment m+2
            if (s >= 2 && trig[s-2] < 0) trig[s-2] = k;
         end
      end
      for (int m = 0; m < NM; m++) begin
         if (e[m] > 64'hFFFF_FFFF) e[m] = 64'hFFFF_FFFF;
      end
      for (int k = 0; k < n_beats; k++) begin
         g = (gap_max == 0) ? 0 : int'($urandom_range(32'(gap_max), 0));
         repeat (g) begin
            @(negedge clk);
            power_valid = 1'b0;
         end
         @(negedge clk);
         power_valid = 1'b1;
         power_in    = frm[k];
         for (int m = 0; m < NM - 1; m++) begin
            if (trig[m] == k) begin
               x.idx  = m;
               x.val  = e[m][31:0];
               x.last = 1'b0;
               x.due  = cyc + 3;
               q.push_back(x);
            end
         end
         if (k == NB - 1) begin
            x.idx  = NM - 1;
            x.val  = e[NM-1][31:0];
            x.last = 1'b1;
            x.due  = cyc + 4;
            q.push_back(x);
         end
      end
      @(negedge clk);
      power_valid = 1'b0;
   endtask

   initial begin
      int cand[$];
      int pick;
      rst         = 1'b1;
      power_valid = 1'b0;
      power_in    = '0;
      for (int k = 0; k < NB; k++) tbl[k] = default_rom_word(32'(k));

      repeat (3) @(negedge clk);
      check("reset_mel_valid", 64'(mel_valid), 0);
      check("reset_frame_done", 64'(frame_done), 0);
      check("reset_mel_out", 64'(mel_out), 0);
      check("reset_mel_index", 64'(mel_index), 0);
      rst = 1'b0;

      // All-zero frame
      for (int k = 0; k < NF; k++) frm[k] = '0;
      run_frame(NF, 0);

      // Single bin at half weight inside a filter pair
      for (int k = 0; k < NB; k++) begin
         if (tbl[k].seg >= 6'd1 && tbl[k].seg <= 6'(NM - 1) && tbl[k].w == 16'h4000)
            cand.push_back(k);
      end
      pick = cand[$urandom_range(32'(cand.size() - 1), 0)];
      for (int k = 0; k < NF; k++) frm[k] = '0;
      frm[pick] = 32'h0001_0000;
      run_frame(NF, 1);

      // Full-scale frame saturates every filter
      for (int k = 0; k < NF; k++) frm[k] = 32'hFFFF_FFFF;
      run_frame(NF, 0);

      // Abort a frame at bin 100, then a clean frame
      for (int k = 0; k < NF; k++) frm[k] = $urandom();
      run_frame(100, 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_mel_valid", 64'(mel_valid), 0);
      rst = 1'b0;
      for (int k = 0; k < NF; k++) frm[k] = 32'h0000_0100;
      run_frame(NF, 0);

      // Two random 16-bit frames with gaps
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NF; k++) frm[k] = 32'($urandom_range(32'hFFFF, 0));
         run_frame(NF, 3);
      end

      // Upper half of the frame is counted but ignored
      for (int k = 0; k < NF; k++) frm[k] = (k < NB) ? 32'h0 : 32'hFFFF_FFFF;
      run_frame(NF, 0);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 64'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no end of test, expected finish within budget");
      $fatal(1, "timeout");
   end

endmodule
